// File: rtl/execute_muldiv_stage.sv
// Iterative RV32M multiply/divide execute unit with operand forwarding resolved in LOAD.
// Optional MULDIV_FAST_MUL_EN: multiplies use one combinational multiplier and skip CALC.
module execute_muldiv_stage #(
  parameter int width_p     = 32,
  parameter int fwd_els_p   = 2,
  parameter int cnt_width_p = $clog2(width_p+1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [2:0]                   funct3_i,
  input  logic [width_p-1:0]           rs1_data_i,
  input  logic [width_p-1:0]           rs2_data_i,
  input  logic [fwd_els_p-1:0]         fwd_rs1_v_i,
  input  logic [fwd_els_p-1:0]         fwd_rs2_v_i,
  input  logic [fwd_els_p*width_p-1:0] fwd_data_i,
  input  logic                         flush_i,
  input  logic                         stall_v_i,
  output logic                         v_o,
  output logic [width_p-1:0]           result_o
);

  // Handshake: an instruction is taken on a clock edge where v_i & ready_o & ~flush_i;
  // a result is consumed on a clock edge where v_o & ~stall_v_i & ~flush_i.
  typedef enum logic [1:0] {st_idle, st_load, st_calc, st_done} state_e;

  state_e                   state_q, state_n;
  logic [2:0]               funct3_q;
  logic [width_p-1:0]       rs1_q, rs2_q;
  logic [width_p-1:0]       opb_q;
  logic [2*width_p:0]       acc_q, acc_step;
  logic [cnt_width_p-1:0]   cnt_q;
  logic                     neg_q;
  logic [width_p-1:0]       result_q;

  logic [width_p-1:0]       op_a, op_b, mag_a, mag_b, special_res, load_res, calc_res;
  logic                     is_div, a_signed, b_signed, a_neg, b_neg, load_neg;
  logic                     div_by_zero, div_ovf, special, load_direct, last_iter;

  function automatic logic [width_p-1:0] mul_final(input logic [2*width_p-1:0] prod,
                                                    input logic neg, input logic [2:0] f3);
    logic [2*width_p-1:0] p;
    p = neg ? -prod : prod;
    return (f3 == 3'd0) ? p[width_p-1:0] : p[2*width_p-1:width_p];
  endfunction

  // Quotient sits in the low half of the accumulator, remainder in the high half.
  function automatic logic [width_p-1:0] div_final(input logic [2*width_p:0] acc,
                                                    input logic neg, input logic [2:0] f3);
    logic [width_p-1:0] q, r;
    q = acc[width_p-1:0];
    r = acc[2*width_p-1:width_p];
    if (f3[1]) return neg ? -r : r;
    return neg ? -q : q;
  endfunction

  // Lowest-index forwarding source wins, so scan from the highest index down.
  always_comb begin
    op_a = rs1_q;
    op_b = rs2_q;
    for (int k = fwd_els_p-1; k >= 0; k--) begin
      if (fwd_rs1_v_i[k]) op_a = fwd_data_i[k*width_p +: width_p];
      if (fwd_rs2_v_i[k]) op_b = fwd_data_i[k*width_p +: width_p];
    end
  end

  always_comb begin
    is_div      = funct3_q[2];
    a_signed    = (funct3_q == 3'd1) || (funct3_q == 3'd2) || (funct3_q == 3'd4) || (funct3_q == 3'd6);
    b_signed    = (funct3_q == 3'd1) || (funct3_q == 3'd4) || (funct3_q == 3'd6);
    a_neg       = a_signed & op_a[width_p-1];
    b_neg       = b_signed & op_b[width_p-1];
    mag_a       = a_neg ? -op_a : op_a;
    mag_b       = b_neg ? -op_b : op_b;
    load_neg    = (is_div && funct3_q[1]) ? a_neg : (a_neg ^ b_neg);
    div_by_zero = is_div && (op_b == '0);
    div_ovf     = is_div && !funct3_q[0] && (op_a == {1'b1, {(width_p-1){1'b0}}}) && (&op_b);
    special     = div_by_zero || div_ovf;
    if (div_by_zero) special_res = funct3_q[1] ? op_a : '1;
    else             special_res = funct3_q[1] ? '0 : {1'b1, {(width_p-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
    load_direct = special || !is_div;
    load_res    = special ? special_res
                          : mul_final({{width_p{1'b0}}, mag_a} * {{width_p{1'b0}}, mag_b}, load_neg, funct3_q);
`else
    load_direct = special;
    load_res    = special_res;
`endif
  end

  // One iteration: shift-add for multiply, shift-subtract-restore for divide.
  always_comb begin
    logic [2*width_p:0] shifted;
    logic [width_p+1:0] diff;
    logic [width_p:0]   sum;
    shifted  = {acc_q[2*width_p-1:0], 1'b0};
    diff     = {1'b0, shifted[2*width_p:width_p]} - {2'b00, opb_q};
    sum      = acc_q[2*width_p:width_p] + (acc_q[0] ? {1'b0, opb_q} : '0);
    acc_step = acc_q;
    if (is_div) begin
      if (!diff[width_p+1]) acc_step = {diff[width_p:0], shifted[width_p-1:1], 1'b1};
      else                  acc_step = shifted;
    end else begin
      acc_step = {1'b0, sum, acc_q[width_p-1:1]};
    end
    calc_res  = is_div ? div_final(acc_step, neg_q, funct3_q)
                       : mul_final(acc_step[2*width_p-1:0], neg_q, funct3_q);
    last_iter = (cnt_q == cnt_width_p'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= st_idle;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (flush_i) state_n = st_idle;
    else begin
      case (state_q)
        st_idle: if (v_i) state_n = st_load;
        st_load: state_n = load_direct ? st_done : st_calc;
        st_calc: if (last_iter) state_n = st_done;
        st_done: if (!stall_v_i) state_n = st_idle;
        default: state_n = st_idle;
      endcase
    end
  end

  always_comb begin
    ready_o  = (state_q == st_idle);
    v_o      = (state_q == st_done);
    result_o = result_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        st_idle: begin
          if (v_i && !flush_i) begin
            funct3_q <= funct3_i;
            rs1_q    <= rs1_data_i;
            rs2_q    <= rs2_data_i;
          end
        end
        st_load: begin
          acc_q <= {{(width_p+1){1'b0}}, mag_a};
          opb_q <= mag_b;
          neg_q <= load_neg;
          cnt_q <= cnt_width_p'(width_p);
          if (load_direct) result_q <= load_res;
        end
        st_calc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - cnt_width_p'(1);
          if (last_iter) result_q <= calc_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/execute_muldiv_stage.md
Name: execute_muldiv_stage

Overview:
- Parametrised iterative RV32M multiply/divide execute unit. It sits beside the single-cycle ALU in the execute stage.
- It captures an instruction's operands and resolves operand forwarding from N younger pipeline stages.
- It computes the result over multiple cycles while holding the pipeline via ready_o, then presents the result until downstream accepts it.

Parameters:
width_p, 32, operand/result width in bits (even, >= 8)
fwd_els_p, 2, number of forwarding sources; index 0 is the nearest (youngest) stage
cnt_width_p, $clog2(width_p+1), iteration counter width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
v_i  in  1  valid muldiv instruction offered this cycle
ready_o  out  1  unit can capture an instruction (state IDLE)
funct3_i  in  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data_i  in  width_p  register-file rs1 value
rs2_data_i  in  width_p  register-file rs2 value
fwd_rs1_v_i  in  fwd_els_p  per-source forward-to-rs1 select
fwd_rs2_v_i  in  fwd_els_p  per-source forward-to-rs2 select
fwd_data_i  in  fwd_els_p*width_p  forward data; source k occupies bits [k*width_p +: width_p]
flush_i  in  1  kill in-flight instruction
stall_v_i  in  1  downstream stall; result held while high
v_o  out  1  result valid
result_o  out  width_p  result

Behaviour:
- Capture:
  - v_i & ready_o at a clock edge registers funct3_i, rs1_data_i and rs2_data_i, and moves to LOAD.
  - v_i while ready_o=0 is ignored; upstream must hold it.
- State machine (IDLE, LOAD, CALC, DONE):
  - IDLE -> LOAD on capture.
  - LOAD -> CALC normally; LOAD -> DONE for special divide cases.
  - CALC -> DONE after width_p iterations.
  - DONE -> IDLE on ~stall_v_i.
- LOAD forwarding:
  - Effective rs1/rs2 is fwd_data_i[k] for the lowest k with fwd_rsX_v_i[k]=1; otherwise the registered value.
  - Forward inputs are sampled only in the LOAD cycle.
- Signedness and operand setup in LOAD:
  - Operands are converted to magnitudes per op signedness (MULH: both signed; MULHSU: rs1 signed, rs2 unsigned).
  - Result sign is recorded.
  - Counter is loaded with width_p.
- Multiply: radix-2 shift-add on a 2*width_p accumulator, one bit per CALC cycle. MUL returns the low half; MULH/MULHSU/MULHU return the high half after sign correction.
- Divide: restoring, one quotient bit per CALC cycle. Quotient sign = sign(rs1) xor sign(rs2). Remainder sign = sign(rs1).
- Special cases, resolved in LOAD with no CALC:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (rs1 = most-negative, rs2 = -1): DIV returns most-negative; REM returns 0.
- Latency, capture edge to first v_o=1 cycle:
  - width_p+2 cycles normal (34 at default).
  - 2 cycles for special cases.
- DONE:
  - v_o=1 and result_o is stable for as long as stall_v_i=1.
  - The result is consumed on the first DONE cycle with stall_v_i=0; the next cycle is IDLE with ready_o=1.
  - No capture occurs in the DONE cycle.
- ready_o = (state==IDLE). v_o = (state==DONE).
- flush_i:
  - In any state, flush_i gives IDLE next cycle with no v_o pulse.
  - flush_i has priority over capture and over the DONE exit; v_i in the same cycle as flush_i is not captured.
- Reset: state IDLE, v_o=0, ready_o=1, result_o=0, counter=0, and all operand/accumulator registers cleared. Reset mid-operation discards the instruction.
- Arithmetic is modulo 2^width_p on outputs. Internal accumulators are 2*width_p+1 bits; no overflow is flagged.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU compute with a single combinational width_p x width_p multiplier in LOAD and go LOAD -> DONE.
  - Multiply latency is 2 cycles; divide is unchanged.
- Undefined: multiply is iterative as above, width_p+2 cycles, and no hardware multiplier is inferred.

Test Plan:
- Basic multiply: MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> v_o after 34 cycles (2 with MULDIV_FAST_MUL_EN), result_o=0xFFFFFFEB; ready_o low throughout.
- High-half multiply: MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV -20/3 -> 0xFFFFFFFA (-6); REM -20/3 -> 0xFFFFFFFE (-2); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases: DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at latency 2. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0.
- Forwarding priority: rs1 register value 1, fwd_rs1_v_i=2'b11, fwd_data[0]=6, fwd_data[1]=9, rs2=4, MUL -> 24 (source 0 wins).
- Stall/flush/reset: stall_v_i held 5 cycles in DONE keeps v_o=1 and result stable, then IDLE the cycle after release. flush_i in CALC cycle 10 gives no v_o and ready_o=1 next cycle. rst_i in CALC gives v_o=0, result_o=0, ready_o=1.
